// File: rtl/rng_pkg.sv
// Shared widths, default parameters and packer state type for the RNG packer.
package rng_pkg;

  localparam int NIBBLE_W       = 4;
  localparam int BYTE_W         = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_REP_LIMIT  = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/rng_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers, level output and flush.
module rng_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !w_empty;
  // A push into a full FIFO only lands when a pop frees the head slot on the same edge.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_valid = !w_empty;
  assign o_full  = w_full;
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush takes priority over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/rng_packer.sv
// Packs LFSR nibble pairs into bytes, screens for stuck output, buffers in a FIFO.
module rng_packer
  import rng_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NIBBLE_W-1:0]         sample_in,
  input  logic                        sample_valid,
  input  logic                        clear,
  output logic [BYTE_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        health_fail
);

  localparam logic [3:0] LIM = 4'(REP_LIMIT);

  pack_state_t         r_state;
  logic [NIBBLE_W-1:0] r_held;
  logic [NIBBLE_W-1:0] r_prev;
  logic                r_have_prev;
  logic [3:0]          r_rep_cnt;
  logic                r_overflow;
  logic                r_health_fail;

  logic [3:0]          w_next_cnt;
  logic                w_trip;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_full;
  logic [BYTE_W-1:0]   w_byte;

  // Repetition count the current sample would produce.
  always_comb begin
    w_next_cnt = 4'd1;
    if (r_have_prev && (sample_in == r_prev)) begin
      w_next_cnt = (r_rep_cnt >= LIM) ? LIM : r_rep_cnt + 4'd1;
    end
  end

  assign w_trip = sample_valid && !clear && (w_next_cnt == LIM);
  assign w_push = sample_valid && !clear && !w_trip && !r_health_fail && (r_state == HALF);
  assign w_pop  = out_valid && out_ready;
  assign w_byte = {r_held, sample_in};

  assign overflow    = r_overflow;
  assign health_fail = r_health_fail;

  // Health test history: previous sample and run length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (clear) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (sample_valid) begin
      r_prev      <= sample_in;
      r_have_prev <= 1'b1;
      r_rep_cnt   <= w_next_cnt;
    end
  end

  // Nibble packer; a tripping sample discards any held half-byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
      r_held  <= '0;
    end else if (clear) begin
      r_state <= EMPTY;
    end else if (sample_valid) begin
      if (w_trip) begin
        r_state <= EMPTY;
      end else if (!r_health_fail) begin
        case (r_state)
          EMPTY: begin
            r_held  <= sample_in;
            r_state <= HALF;
          end
          HALF: r_state <= EMPTY;
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

  // Sticky flags, cleared only by clear or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow    <= 1'b0;
      r_health_fail <= 1'b0;
    end else if (clear) begin
      r_overflow    <= 1'b0;
      r_health_fail <= 1'b0;
    end else begin
      if (w_trip) r_health_fail <= 1'b1;
      if (w_push && w_fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  rng_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_flush (clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_byte),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_full  (w_fifo_full),
    .o_level (fifo_level)
  );

endmodule

// File: tb/tb_rng_packer.sv
// Directed test of rng_packer against a queue-based reference model.
module tb_rng_packer;

  localparam int DEPTH = 4;
  localparam int REP   = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       health_fail;

  int total = 0;
  int bad   = 0;

  rng_packer #(
    .FIFO_DEPTH (DEPTH),
    .REP_LIMIT  (REP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear        (clear),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .health_fail  (health_fail)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_q[$];
  logic [3:0] m_half = '0;
  bit         m_half_v = 0;
  logic [3:0] m_prev = '0;
  bit         m_has_prev = 0;
  int         m_cnt = 0;
  bit         m_ov = 0;
  bit         m_hf = 0;

  // Bytes actually handed to the consumer by the DUT
  logic [7:0] got[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: behaviour from the rules, expressed with a byte queue.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_half_v = 0; m_has_prev = 0; m_cnt = 0; m_ov = 0; m_hf = 0;
    end else if (clear) begin
      m_q.delete();
      m_half_v = 0; m_has_prev = 0; m_cnt = 0; m_ov = 0; m_hf = 0;
    end else begin
      bit         pop;
      bit         push;
      logic [7:0] b;
      pop  = (m_q.size() != 0) && out_ready;
      push = 0;
      b    = '0;
      if (sample_valid) begin
        if (!m_has_prev || sample_in != m_prev) m_cnt = 1;
        else if (m_cnt < REP) m_cnt++;
        m_prev = sample_in;
        m_has_prev = 1;
        if (m_cnt == REP) begin
          m_hf = 1;
          m_half_v = 0;
        end else if (!m_hf) begin
          if (m_half_v) begin
            push = 1;
            b = {m_half, sample_in};
            m_half_v = 0;
          end else begin
            m_half = sample_in;
            m_half_v = 1;
          end
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ov = 1;
      end
    end
  end

  // Record every byte the consumer accepts (pre-edge values)
  always @(posedge clk) begin
    if (reset_n && !clear && out_valid && out_ready) got.push_back(out_data);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("out_valid",   32'(out_valid),   32'(m_q.size() != 0));
    chk("out_data",    32'(out_data),    (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    chk("fifo_level",  32'(fifo_level),  32'(m_q.size()));
    chk("overflow",    32'(overflow),    32'(m_ov));
    chk("health_fail", 32'(health_fail), 32'(m_hf));
  end

  task automatic drive(input logic v, input logic [3:0] s, input logic rdy, input logic clr);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
    out_ready    = rdy;
    clear        = clr;
  endtask

  task automatic check_bytes(input string name, input logic [63:0] v, input int n);
    chk({name, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk(name, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
          32'(v >> (8 * (n - 1 - i))) & 32'hFF);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);

    // A, 5 -> single byte A5
    drive(1, 4'hA, 1, 0);
    drive(1, 4'h5, 1, 0);
    drive(0, 4'h0, 1, 0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data",  32'(out_data),  32'hA5);
    drive(0, 4'h0, 1, 0);
    chk("t1_level", 32'(fifo_level), 32'h0);
    check_bytes("t1_bytes", 64'hA5, 1);

    // Overflow: 10 nibbles with consumer stalled
    got.delete();
    for (int i = 1; i <= 10; i++) drive(1, 4'(i), 0, 0);
    drive(0, 4'h0, 0, 0);
    chk("t2_level", 32'(fifo_level), 32'h4);
    chk("t2_ovf",   32'(overflow),   32'h1);
    repeat (5) drive(0, 4'h0, 1, 0);
    drive(0, 4'h0, 0, 0);
    check_bytes("t2_bytes", 64'h12345678, 4);
    chk("t2_ovf_sticky", 32'(overflow), 32'h1);
    drive(0, 4'h0, 1, 1);
    drive(0, 4'h0, 1, 0);
    chk("t2_ovf_clr", 32'(overflow), 32'h0);

    // Stuck-at-zero source trips the health test
    got.delete();
    repeat (6) drive(1, 4'h0, 1, 0);
    drive(0, 4'h0, 1, 0);
    chk("t3_hf", 32'(health_fail), 32'h1);
    drive(1, 4'h3, 1, 0);
    drive(1, 4'h4, 1, 0);
    drive(0, 4'h0, 1, 0);
    drive(0, 4'h0, 1, 0);
    check_bytes("t3_bytes", 64'h0000, 2);
    drive(0, 4'h0, 1, 1);
    drive(1, 4'h3, 1, 0);
    drive(1, 4'hC, 1, 0);
    drive(0, 4'h0, 1, 0);
    drive(0, 4'h0, 1, 0);
    chk("t3_hf_clr", 32'(health_fail), 32'h0);
    check_bytes("t3_after", 64'h00003C, 3);

    // Full FIFO with push and pop on the same edge
    got.delete();
    for (int i = 1; i <= 8; i++) drive(1, 4'(i), 0, 0);
    drive(1, 4'hB, 0, 0);
    drive(1, 4'hC, 1, 0);
    drive(0, 4'h0, 0, 0);
    chk("t4_level", 32'(fifo_level), 32'h4);
    chk("t4_ovf",   32'(overflow),   32'h0);
    repeat (5) drive(0, 4'h0, 1, 0);
    drive(0, 4'h0, 0, 0);
    check_bytes("t4_bytes", 64'h12345678BC, 5);

    // Clear flushes queued byte and half-byte, ignores its own sample
    got.delete();
    drive(1, 4'h6, 0, 0);
    drive(1, 4'h5, 0, 0);
    drive(1, 4'h7, 0, 0);
    drive(1, 4'h9, 0, 1);
    drive(1, 4'h1, 1, 0);
    drive(1, 4'h2, 1, 0);
    repeat (3) drive(0, 4'h0, 1, 0);
    check_bytes("t5_bytes", 64'h12, 1);

    // Asynchronous reset mid-byte with 3 bytes queued
    got.delete();
    for (int i = 1; i <= 7; i++) drive(1, 4'(i), 0, 0);
    drive(0, 4'h0, 0, 0);
    chk("t6_pre_level", 32'(fifo_level), 32'h3);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid),   32'h0);
    chk("t6_data",  32'(out_data),    32'h0);
    chk("t6_level", 32'(fifo_level),  32'h0);
    chk("t6_ovf",   32'(overflow),    32'h0);
    chk("t6_hf",    32'(health_fail), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 4'h8, 1, 0);
    drive(1, 4'h9, 1, 0);
    drive(0, 4'h0, 1, 0);
    drive(0, 4'h0, 1, 0);
    check_bytes("t6_bytes", 64'h89, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rng_packer.md
# rng_packer

Downstream stage of the 4-bit `lfsr`. It accepts one nibble per `sample_valid` and packs nibble pairs into bytes. It screens the nibble stream with a repetition-count health test and buffers bytes in a small FIFO. Bytes are delivered to the consumer (UART/SPI front-end or output pins) over a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO depth; power of two, ≥2.
- `REP_LIMIT`, default 6: count of consecutive identical nibbles that trips the health test; range 2..15.

Ports:
- `clk`  in  1: clock; all state on rising edge.
- `reset_n`  in  1: reset, asynchronous assert, active-low.
- `sample_in`  in  4: nibble from `lfsr_out`.
- `sample_valid`  in  1: `sample_in` is a new sample this cycle.
- `clear`  in  1: synchronous flush and sticky-flag clear.
- `out_data`  out  8: byte at FIFO head; 8'h00 when `out_valid`=0.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts the head byte.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: bytes held.
- `overflow`  out  1: sticky; a byte was dropped because the FIFO was full.
- `health_fail`  out  1: sticky; repetition limit reached.

## Operation
- Reset values: `out_valid`=0, `out_data`=8'h00, `fifo_level`=0, `overflow`=0, `health_fail`=0. Internally: half-byte empty, rep count 0, no previous sample.
- **Health test** runs on every `sample_valid`, including while `health_fail`=1.
  - First sample after reset or clear: rep count = 1.
  - Sample equal to the previous sample: count += 1, saturating at `REP_LIMIT`.
  - Otherwise: count = 1.
  - When the count reaches `REP_LIMIT`, `health_fail` sets. That sample is not packed, and any held half-byte is discarded.
- **Packer**, active only while `health_fail`=0. Two states, EMPTY and HALF.
  - EMPTY + valid: store nibble as the high half; go to HALF.
  - HALF + valid: push byte {held, `sample_in`}; go to EMPTY.
- **FIFO**: push at the edge of the second nibble; pop at an edge with `out_valid` && `out_ready`. Bytes leave in push order.
  - Full + push + no pop: byte dropped, `overflow` sets, FIFO unchanged.
  - Full + push + pop, same edge: both happen, level stays `FIFO_DEPTH`, no overflow.
  - Empty + push: no pop possible that edge, because `out_valid` was 0.
- **`clear`**, highest priority over sample, push and pop in the same cycle:
  - FIFO emptied, packer to EMPTY, rep count 0, previous sample forgotten.
  - `overflow` and `health_fail` go to 0.
  - The sample presented in the `clear` cycle is ignored.
- `reset_n` low at any time immediately forces all reset values, including mid-byte and mid-handshake.

## Timing
- Latency: second nibble sampled at edge N into an empty FIFO gives `out_valid`=1 and the byte on `out_data` during cycle N+1.
- `out_valid`, `out_data`, `fifo_level`, `overflow` and `health_fail` come from registers. There is no combinational path from inputs to outputs.
- `overflow` and `health_fail` are visible the cycle after the offending edge.
- `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
- Back-to-back `sample_valid` is supported, giving at most one byte per 2 cycles. The consumer may pop every cycle.

## Structure
- Package `rng_pkg`:
  - `NIBBLE_W`=4 and `BYTE_W`=8.
  - Default `FIFO_DEPTH` and `REP_LIMIT`.
  - Packer state enum {EMPTY, HALF}.
- Sub-module `rng_fifo`: parameterised synchronous FIFO.
  - Read/write pointers with a wrap bit; level output; `flush` input driven by `clear`.
  - Push/pop handling is as specified in Operation.
- Top holds the packer FSM, the health test and the sticky flags.

## Test plan
- Reset, then nibbles 4'hA, 4'h5 with `out_ready`=1: `out_data`=8'hA5 with `out_valid` for one cycle; `fifo_level` returns to 0.
- `out_ready`=0, 10 nibbles 1..A:
  - `fifo_level`=4 and `overflow`=1 after the 5th byte.
  - Draining yields 8'h12, 34, 56, 78; byte 8'h9A is lost.
- Constant 4'h0 on six valid cycles (stuck upstream `lfsr` seeded with 0), `REP_LIMIT`=6:
  - Two 8'h00 bytes pushed.
  - `health_fail`=1 after the 6th sample; no further pushes.
  - `clear` restores normal packing.
- FIFO full, `out_ready`=1 on the same edge a byte completes: level stays 4, `overflow` stays 0, order preserved.
- Nibble 4'h7, then `clear` together with a sample, then 4'h1, 4'h2: only 8'h12 emerges; FIFO was flushed.
- `reset_n` pulsed low mid-byte with 3 bytes queued: all outputs go to reset values without a clock edge; the next nibble pair packs cleanly.
